transmit_beamformer: RTL

//  Transmit-side counterpart of the receive beamformer. Drives NUM_TRANSMITTERS ultrasonic elements with gated

---
 rtl/tx_beam_pkg.sv | 40 ++++
 rtl/tx_element_driver.sv | 78 +++++++
 rtl/transmit_beamformer.sv | 114 +++++++++++
 3 files changed

// File: rtl/tx_beam_pkg.sv
// Shared constants, types and the steering-delay helper for the transmit beamformer.
package tx_beam_pkg;

  localparam int CLK_FREQ        = 100000000;
  localparam int TARGET_FREQ     = 40000;
  localparam int ELEMENT_SPACING = 9;
  localparam int SPEED_OF_SOUND  = 343000;
  localparam int SIN_WIDTH       = 17;
  localparam int DELAY_WIDTH     = 16;

  // Carrier half period and element-to-element acoustic flight time, in clocks.
  localparam int HALF_PERIOD  = CLK_FREQ / (2 * TARGET_FREQ);
  localparam int CYC_PER_ELEM = int'((longint'(ELEMENT_SPACING) * longint'(CLK_FREQ))
                                     / longint'(SPEED_OF_SOUND));

  typedef enum logic {IDLE, RUN} state_t;

  typedef logic [DELAY_WIDTH-1:0] delay_t;

  // Start delay of one element: flight time scaled by the saturated |sin|, with the
  // element ordering reversed when steering left so element 0 fires last.
  function automatic delay_t calc_delay(input logic [SIN_WIDTH-1:0] sin_theta,
                                        input logic sign_bit,
                                        input int index,
                                        input int num);
    logic [63:0] sin_sat;
    logic [63:0] k;
    logic [63:0] prod;
    logic [63:0] shifted;
    if (sin_theta > SIN_WIDTH'(1 << (SIN_WIDTH-1)))
      sin_sat = 64'(1) << (SIN_WIDTH-1);
    else
      sin_sat = 64'(sin_theta);
    k       = sign_bit ? 64'(num - 1 - index) : 64'(index);
    prod    = 64'(CYC_PER_ELEM) * k * sin_sat;
    shifted = prod >> (SIN_WIDTH-1);
    return shifted[DELAY_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/tx_element_driver.sv
// One transmit element: holds its start delay and the carrier phase counter, and
// emits the gated square wave (plus the complementary leg under TX_COMPLEMENT_EN).
module tx_element_driver
  import tx_beam_pkg::*;
#(
  parameter int CW             = 24,
  parameter int BURST_DURATION = 524288
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          latch,
  input  delay_t        delay_next,
  input  logic [CW-1:0] period_count,
  output logic          tx,
`ifdef TX_COMPLEMENT_EN
  output logic          tx_n,
`endif
  output logic          active
);

  localparam int PW = $clog2(2 * HALF_PERIOD);

  delay_t        delay;
  logic [PW-1:0] phase;
  logic [31:0]   count_ext;
  logic [31:0]   start_ext;
  logic [31:0]   stop_ext;
  logic          in_window;
  logic          at_start;
  logic          tx_level;

  // Window test and carrier level for the current period count.
  always_comb begin
    count_ext = 32'(period_count);
    start_ext = 32'(delay);
    stop_ext  = start_ext + 32'(BURST_DURATION);
    in_window = run && (count_ext >= start_ext) && (count_ext < stop_ext);
    at_start  = (count_ext == start_ext);
    tx_level  = at_start ? 1'b1 : (phase < PW'(HALF_PERIOD));
  end

  // Delay latch, phase counter and registered drive outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay  <= '0;
      phase  <= '0;
      tx     <= 1'b0;
      active <= 1'b0;
`ifdef TX_COMPLEMENT_EN
      tx_n   <= 1'b0;
`endif
    end else begin
      if (latch)
        delay <= delay_next;
      if (in_window) begin
        active <= 1'b1;
        tx     <= tx_level;
`ifdef TX_COMPLEMENT_EN
        tx_n   <= ~tx_level;
`endif
        if (at_start)
          phase <= PW'(1);
        else if (phase == PW'(2 * HALF_PERIOD - 1))
          phase <= '0;
        else
          phase <= phase + PW'(1);
      end else begin
        active <= 1'b0;
        tx     <= 1'b0;
`ifdef TX_COMPLEMENT_EN
        tx_n   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/transmit_beamformer.sv
// Transmit beamformer top: ping-period FSM, period counter, steering-delay latch
// and per-element drivers. Define TX_COMPLEMENT_EN to add the tx_n_out H-bridge leg.
module transmit_beamformer
  import tx_beam_pkg::*;
#(
  parameter int PERIOD_DURATION  = 16777216,
  parameter int BURST_DURATION   = 524288,
  parameter int NUM_TRANSMITTERS = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        enable_in,
  input  logic [SIN_WIDTH-1:0]        sin_theta,
  input  logic                        sign_bit,
  output logic [NUM_TRANSMITTERS-1:0] tx_out,
  output logic                        burst_active_out,
  output logic                        period_start_out,
  output logic                        busy_out
`ifdef TX_COMPLEMENT_EN
  ,
  output logic [NUM_TRANSMITTERS-1:0] tx_n_out
`endif
);

  localparam int CW = $clog2(PERIOD_DURATION);

  if (NUM_TRANSMITTERS < 2) begin : g_bad_count
    $error("transmit_beamformer: NUM_TRANSMITTERS must be at least 2");
  end
  if (longint'(PERIOD_DURATION) <= longint'(CYC_PER_ELEM) * longint'(NUM_TRANSMITTERS - 1)
                                   + longint'(BURST_DURATION)) begin : g_bad_period
    $error("transmit_beamformer: PERIOD_DURATION too short for steering delay plus burst");
  end

  state_t                      state;
  state_t                      next_state;
  logic [CW-1:0]               period_count;
  logic                        at_wrap;
  logic                        load;
  logic                        run;
  logic [NUM_TRANSMITTERS-1:0] active;
  delay_t                      delay_next [NUM_TRANSMITTERS];

  // Period boundary and the delay-latch / restart strobe.
  always_comb begin
    at_wrap = (period_count == CW'(PERIOD_DURATION - 1));
    run     = (state == RUN);
    load    = enable_in && ((state == IDLE) || at_wrap);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic: start on enable, stop only at the end of a full period.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable_in) next_state = RUN;
      RUN:     if (at_wrap && !enable_in) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_out = (state == RUN);
  end

  // Period counter and the one-cycle period start pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      period_count     <= '0;
      period_start_out <= 1'b0;
    end else begin
      period_start_out <= load;
      if (run && !at_wrap)
        period_count <= period_count + CW'(1);
      else
        period_count <= '0;
    end
  end

  for (genvar i = 0; i < NUM_TRANSMITTERS; i++) begin : g_elem
    assign delay_next[i] = calc_delay(sin_theta, sign_bit, i, NUM_TRANSMITTERS);

    tx_element_driver #(
      .CW             (CW),
      .BURST_DURATION (BURST_DURATION)
    ) u_drv (
      .clk          (clk_in),
      .rst          (rst_in),
      .run          (run),
      .latch        (load),
      .delay_next   (delay_next[i]),
      .period_count (period_count),
      .tx           (tx_out[i]),
`ifdef TX_COMPLEMENT_EN
      .tx_n         (tx_n_out[i]),
`endif
      .active       (active[i])
    );
  end

  // Any element inside its window.
  always_comb begin
    burst_active_out = |active;
  end

endmodule
